// File: rtl/counter_sequencer_if.sv
// Button and counter-control bundle between the board front-end and counter_sequencer.
interface counter_sequencer_if;
  logic       btn_run;
  logic       btn_step;
  logic       btn_dir;
  logic       btn_max;
  logic       btn_clr;
  logic [2:0] count;
  logic       enable;
  logic       direction;
  logic [2:0] max_count;
  logic       counter_reset;
  logic       running;

  modport master (
    output btn_run, btn_step, btn_dir, btn_max, btn_clr, count,
    input  enable, direction, max_count, counter_reset, running
  );

  modport slave (
    input  btn_run, btn_step, btn_dir, btn_max, btn_clr, count,
    output enable, direction, max_count, counter_reset, running
  );
endinterface

// File: rtl/counter_sequencer.sv
// Push-button sequencer for the 3-bit up/down counter: run/pause tick, single step, clear, dir, bound.
// Optional COUNTER_AUTO_REVERSE_EN: flip direction on a run tick taken at a counting bound (ping-pong).
module counter_sequencer #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input logic                clock,
  input logic                reset,
  counter_sequencer_if.slave bus
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_TOP = PRESC_W'(TICK_DIV - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] STEP  = 2'd2;
  localparam logic [1:0] CLEAR = 2'd3;

  localparam int unsigned B_MAX  = 0;
  localparam int unsigned B_DIR  = 1;
  localparam int unsigned B_STEP = 2;
  localparam int unsigned B_RUN  = 3;
  localparam int unsigned B_CLR  = 4;

  logic [1:0]         state, state_d;
  logic [PRESC_W-1:0] presc, presc_d;
  logic [4:0]         btn, btn_q, btn_edge;
  logic               wrap;
  logic               enable_d, counter_reset_d, running_d, direction_d;
  logic [2:0]         max_count_d;

  assign btn      = {bus.btn_clr, bus.btn_run, bus.btn_step, bus.btn_dir, bus.btn_max};
  assign btn_edge = btn & ~btn_q;

  // Next-state, prescaler and output decode
  always_comb begin
    state_d         = state;
    presc_d         = presc;
    wrap            = 1'b0;
    direction_d     = bus.direction;
    max_count_d     = bus.max_count;

    case (state)
      IDLE: begin
        if (btn_edge[B_RUN])       state_d = RUN;
        else if (btn_edge[B_STEP]) state_d = STEP;
      end
      RUN:     if (btn_edge[B_RUN]) state_d = IDLE;
      STEP:    state_d = IDLE;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (btn_edge[B_CLR]) state_d = CLEAR;

    // Prescaler advances on every RUN cycle; a tick on the exit edge is dropped
    if (state == RUN) begin
      wrap    = (presc == PRESC_TOP);
      presc_d = wrap ? '0 : presc + PRESC_W'(1);
    end
    if (state == CLEAR || state_d == CLEAR) presc_d = '0;

    enable_d        = (state_d == STEP) || (wrap && state_d == RUN);
    counter_reset_d = (state_d == CLEAR);
    running_d       = (state_d == RUN);

`ifdef COUNTER_AUTO_REVERSE_EN
    // A bound hit overrides a coincident dir press so only one toggle occurs
    if (wrap && state_d == RUN &&
        (bus.direction ? (bus.count == bus.max_count) : (bus.count == 3'd0)))
      direction_d = ~bus.direction;
    else if (btn_edge[B_DIR])
      direction_d = ~bus.direction;
`else
    if (btn_edge[B_DIR]) direction_d = ~bus.direction;
`endif

    if (btn_edge[B_MAX])
      max_count_d = (bus.max_count == 3'd7) ? 3'd1 : bus.max_count + 3'd1;
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= IDLE;
      presc             <= '0;
      // Track the buttons during reset so a press held through reset is not an edge
      btn_q             <= btn;
      bus.enable        <= 1'b0;
      bus.counter_reset <= 1'b0;
      bus.running       <= 1'b0;
      bus.direction     <= 1'b1;
      bus.max_count     <= 3'd7;
    end else begin
      state             <= state_d;
      presc             <= presc_d;
      btn_q             <= btn;
      bus.enable        <= enable_d;
      bus.counter_reset <= counter_reset_d;
      bus.running       <= running_d;
      bus.direction     <= direction_d;
      bus.max_count     <= max_count_d;
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer with TICK_DIV=4 and a behavioural 3-bit counter on count.
module tb_counter_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int S_RUN = 0, S_EN = 1, S_CR = 2, S_DIR = 3, S_MAX = 4, S_CNT = 5;

  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] cnt;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  int         pp_cnt[8];
  int         pp_dir[8];

  counter_sequencer_if bus();

  counter_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Behavioural counter that the sequencer drives
  always @(posedge clock) begin
    if (reset || bus.counter_reset) cnt <= 3'd0;
    else if (bus.enable) begin
      if (bus.direction) cnt <= (cnt == bus.max_count) ? 3'd0 : cnt + 3'd1;
      else               cnt <= (cnt == 3'd0) ? bus.max_count : cnt - 3'd1;
    end
  end
  assign bus.count = cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic string sel_name(input int sel);
    case (sel)
      S_RUN:   return "running";
      S_EN:    return "enable";
      S_CR:    return "counter_reset";
      S_DIR:   return "direction";
      S_MAX:   return "max_count";
      default: return "count";
    endcase
  endfunction

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_RUN:   return 32'(bus.running);
      S_EN:    return 32'(bus.enable);
      S_CR:    return 32'(bus.counter_reset);
      S_DIR:   return 32'(bus.direction);
      S_MAX:   return 32'(bus.max_count);
      default: return 32'(bus.count);
    endcase
  endfunction

  task automatic push(input int c, input int sel, input int v);
    exp_t e;
    e.cyc = c;
    e.sel = sel;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic push_idle_defaults(input int c);
    push(c, S_RUN, 0);
    push(c, S_EN, 0);
    push(c, S_CR, 0);
    push(c, S_DIR, 1);
    push(c, S_MAX, 7);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Pop and compare every expectation that falls due in the current cycle
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        check_eq(sel_name(sb[i].sel), obs(sb[i].sel), 32'(sb[i].val));
        sb.delete(i);
      end else if (sb[i].cyc < cyc) begin
        check_eq("stale_entry", 32'(sb[i].cyc), 32'(cyc));
        sb.delete(i);
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog cycle=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef COUNTER_AUTO_REVERSE_EN
    pp_cnt = '{0, 1, 2, 3, 2, 1, 0, 1};
    pp_dir = '{1, 1, 1, 0, 0, 0, 1, 1};
`else
    pp_cnt = '{0, 1, 2, 3, 0, 1, 2, 3};
    pp_dir = '{1, 1, 1, 1, 1, 1, 1, 1};
`endif
    bus.btn_run  = 1'b0;
    bus.btn_step = 1'b0;
    bus.btn_dir  = 1'b1;
    bus.btn_max  = 1'b0;
    bus.btn_clr  = 1'b0;

    // Reset values, with dir held through reset and released afterwards
    for (int c = 2; c <= 9; c++) push_idle_defaults(c);
    wait_cyc(3); reset = 1'b0;
    wait_cyc(5); bus.btn_dir = 1'b0;

    // Run, pause, resume, clear against a pending tick
    for (int c = 10; c <= 34; c++) begin
      push(c, S_RUN, ((c >= 11 && c <= 17) || (c >= 26 && c <= 30)) ? 1 : 0);
      push(c, S_EN, (c == 15 || c == 27) ? 1 : 0);
      push(c, S_CR, (c == 31) ? 1 : 0);
    end
    for (int c = 31; c <= 33; c++) begin
      push(c, S_DIR, 1);
      push(c, S_MAX, 7);
    end
    wait_cyc(10); bus.btn_run = 1'b1;
    wait_cyc(11); bus.btn_run = 1'b0;
    wait_cyc(17); bus.btn_run = 1'b1;
    wait_cyc(18); bus.btn_run = 1'b0;
    wait_cyc(25); bus.btn_run = 1'b1;
    wait_cyc(26); bus.btn_run = 1'b0;
    wait_cyc(30); bus.btn_clr = 1'b1;
    wait_cyc(31); bus.btn_clr = 1'b0;

    // Single steps, then a step held for ten cycles
    for (int c = 40; c <= 65; c++) begin
      push(c, S_EN, (c == 41 || c == 45 || c == 49 || c == 53) ? 1 : 0);
      push(c, S_RUN, 0);
    end
    for (int k = 0; k < 3; k++) begin
      wait_cyc(40 + 4 * k); bus.btn_step = 1'b1;
      wait_cyc(41 + 4 * k); bus.btn_step = 1'b0;
    end
    wait_cyc(52); bus.btn_step = 1'b1;
    wait_cyc(62); bus.btn_step = 1'b0;

    // Step press while running adds no pulse
    for (int c = 70; c <= 84; c++) begin
      push(c, S_RUN, (c >= 71 && c <= 80) ? 1 : 0);
      push(c, S_EN, (c == 75 || c == 79) ? 1 : 0);
    end
    wait_cyc(70); bus.btn_run = 1'b1;
    wait_cyc(71); bus.btn_run = 1'b0;
    wait_cyc(76); bus.btn_step = 1'b1;
    wait_cyc(77); bus.btn_step = 1'b0;
    wait_cyc(80); bus.btn_run = 1'b1;
    wait_cyc(81); bus.btn_run = 1'b0;

    // max_count cycles 1..7 without passing through 0, then two dir toggles
    for (int c = 90; c <= 110; c++) begin
      push(c, S_MAX, (c < 91) ? 7 : (((c - 91) / 2 + 1 > 7) ? 7 : (c - 91) / 2 + 1));
      push(c, S_DIR, (c == 107 || c == 108) ? 0 : 1);
    end
    for (int k = 0; k < 7; k++) begin
      wait_cyc(90 + 2 * k); bus.btn_max = 1'b1;
      wait_cyc(91 + 2 * k); bus.btn_max = 1'b0;
    end
    wait_cyc(106); bus.btn_dir = 1'b1;
    wait_cyc(107); bus.btn_dir = 1'b0;
    wait_cyc(108); bus.btn_dir = 1'b1;
    wait_cyc(109); bus.btn_dir = 1'b0;

    // Run, clr, dir and max all pressed together
    push(116, S_CR, 1); push(116, S_RUN, 0); push(116, S_EN, 0);
    push(116, S_DIR, 0); push(116, S_MAX, 1);
    push(117, S_CR, 0); push(117, S_RUN, 0);
    wait_cyc(115);
    bus.btn_run = 1'b1; bus.btn_clr = 1'b1; bus.btn_dir = 1'b1; bus.btn_max = 1'b1;
    wait_cyc(116);
    bus.btn_run = 1'b0; bus.btn_clr = 1'b0; bus.btn_dir = 1'b0; bus.btn_max = 1'b0;

    // Reset mid-RUN just before a tick is due
    for (int c = 121; c <= 124; c++) push(c, S_RUN, 1);
    for (int c = 120; c <= 124; c++) push(c, S_EN, 0);
    for (int c = 125; c <= 129; c++) push_idle_defaults(c);
    wait_cyc(120); bus.btn_run = 1'b1;
    wait_cyc(121); bus.btn_run = 1'b0;
    wait_cyc(124); reset = 1'b1;
    wait_cyc(126); reset = 1'b0;

    // Bound behaviour with max_count=3 and the counter model closing the loop
    push(131, S_MAX, 1); push(133, S_MAX, 2); push(135, S_MAX, 3);
    push(137, S_CR, 1); push(138, S_CR, 0);
    for (int c = 141; c <= 175; c++) begin
      if (c >= 145 && ((c - 145) % 4) == 0) begin
        push(c, S_EN, 1);
        push(c, S_CNT, pp_cnt[(c - 145) / 4]);
        push(c, S_DIR, pp_dir[(c - 145) / 4]);
      end else begin
        push(c, S_EN, 0);
      end
      push(c, S_MAX, 3);
    end
    for (int k = 0; k < 3; k++) begin
      wait_cyc(130 + 2 * k); bus.btn_max = 1'b1;
      wait_cyc(131 + 2 * k); bus.btn_max = 1'b0;
    end
    wait_cyc(136); bus.btn_clr = 1'b1;
    wait_cyc(137); bus.btn_clr = 1'b0;
    wait_cyc(140); bus.btn_run = 1'b1;
    wait_cyc(141); bus.btn_run = 1'b0;

    wait_cyc(180);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
